writeback_regfile: RTL and testbench

- Write-back end of the sequential Y86-64 register interface: owns the 15-entry x 64-bit register file that decode reads.
- Per retiring instruction, derives the E and M destinations from icode/rA/rB/cnd and commits valE/valM on the clock edge.
- Provides combinational read ports for decode, a sticky halt/error status and a retired-instruction counter.

---
 rtl/writeback_regfile.sv | 100 ++++++++++
 tb/tb_writeback_regfile.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/writeback_regfile.sv
// Write-back stage of the sequential Y86-64 core: 15 x DATA_W register file,
// E/M destination decode, sticky halt/error status and retire counter.
module writeback_regfile #(
  parameter int unsigned         DATA_W   = 64,
  parameter int unsigned         CNT_W    = 32,
  parameter logic [DATA_W-1:0]   RSP_INIT = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              cnd,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  output logic [3:0]        dstE,
  output logic [3:0]        dstM,
  output logic              halted,
  output logic              instr_err,
  output logic [CNT_W-1:0]  retired
);

  localparam int unsigned NREG     = 15;
  localparam logic [3:0]  REG_NONE = 4'hF;
  localparam logic [3:0]  REG_RSP  = 4'h4;

  logic [DATA_W-1:0] r_regs [0:NREG-1];
  logic              r_halted;
  logic              r_instr_err;
  logic [CNT_W-1:0]  r_retired;

  logic [3:0] w_dst_e;
  logic [3:0] w_dst_m;
  logic       w_accept;
  logic       w_icode_bad;

  // Destination decode from the retiring instruction's fields
  always_comb begin
    w_dst_e = REG_NONE;
    w_dst_m = REG_NONE;
    if (wb_valid) begin
      unique case (icode)
        4'h2:                      w_dst_e = cnd ? rB : REG_NONE;
        4'h3, 4'h6:                w_dst_e = rB;
        4'h8, 4'h9, 4'hA, 4'hB:    w_dst_e = REG_RSP;
        default:                   w_dst_e = REG_NONE;
      endcase
    end
    unique case (icode)
      4'h5, 4'hB: w_dst_m = rA;
      default:    w_dst_m = REG_NONE;
    endcase
  end

  assign w_accept    = wb_valid & ~r_halted;
  assign w_icode_bad = (icode > 4'hB);

  // Register array, status flags and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        r_regs[i] <= (i == int'(REG_RSP)) ? RSP_INIT : '0;
      end
      r_halted    <= 1'b0;
      r_instr_err <= 1'b0;
      r_retired   <= '0;
    end else if (w_accept) begin
      if (w_icode_bad) begin
        r_halted    <= 1'b1;
        r_instr_err <= 1'b1;
      end else begin
        // M port wins when both target the same register
        if ((w_dst_e != REG_NONE) && (w_dst_e != w_dst_m)) begin
          r_regs[w_dst_e] <= valE;
        end
        if (w_dst_m != REG_NONE) begin
          r_regs[w_dst_m] <= valM;
        end
        r_retired <= r_retired + CNT_W'(1);
        if (icode == 4'h0) begin
          r_halted <= 1'b1;
        end
      end
    end
  end

  assign valA      = (srcA == REG_NONE) ? '0 : r_regs[srcA];
  assign valB      = (srcB == REG_NONE) ? '0 : r_regs[srcB];
  assign dstE      = w_dst_e;
  assign dstM      = w_dst_m;
  assign halted    = r_halted;
  assign instr_err = r_instr_err;
  assign retired   = r_retired;

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: directed vector table, async-reset sequences
// and randomized retirements against an array-based reference model.
module tb_writeback_regfile;

  localparam logic [63:0] RSP0 = 64'h100;

  logic        clk, rst_n, wb_valid, cnd;
  logic [3:0]  icode, rA, rB, srcA, srcB;
  logic [63:0] valE, valM, valA, valB;
  logic [3:0]  dstE, dstM;
  logic        halted, instr_err;
  logic [31:0] retired;

  writeback_regfile #(.DATA_W(64), .CNT_W(32), .RSP_INIT(RSP0)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .icode(icode),
    .rA(rA), .rB(rB), .cnd(cnd), .valE(valE), .valM(valM),
    .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
    .dstE(dstE), .dstM(dstM), .halted(halted), .instr_err(instr_err),
    .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: index 15 is a permanent zero so "none" reads fall out
  logic [63:0] m_regs [16];
  logic        m_halted, m_err;
  logic [31:0] m_ret;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [3:0] m_dste(input logic v, input logic [3:0] ic,
                                        input logic [3:0] rb, input logic c);
    if (!v) return 4'hF;
    if (ic == 4'h2) return c ? rb : 4'hF;
    if (ic == 4'h3 || ic == 4'h6) return rb;
    if (ic >= 4'h8 && ic <= 4'hB) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dstm(input logic [3:0] ic, input logic [3:0] ra);
    return (ic == 4'h5 || ic == 4'hB) ? ra : 4'hF;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 64'd0;
    m_regs[4] = RSP0;
    m_halted  = 1'b0;
    m_err     = 1'b0;
    m_ret     = 32'd0;
  endtask

  task automatic model_step();
    logic [3:0] de, dm;
    if (!wb_valid || m_halted) return;
    if (icode > 4'hB) begin
      m_halted = 1'b1;
      m_err    = 1'b1;
      return;
    end
    de = m_dste(1'b1, icode, rB, cnd);
    dm = m_dstm(icode, rA);
    if (de != 4'hF) m_regs[de] = valE;
    if (dm != 4'hF) m_regs[dm] = valM;
    m_ret = m_ret + 32'd1;
    if (icode == 4'h0) m_halted = 1'b1;
  endtask

  // Entered at a negedge; leaves at the next negedge
  task automatic run_cycle(input logic v, input logic [3:0] ic, input logic [3:0] ra,
                           input logic [3:0] rb, input logic c, input logic [63:0] ve,
                           input logic [63:0] vm, input logic [3:0] sa, input logic [3:0] sb);
    wb_valid = v; icode = ic; rA = ra; rB = rb; cnd = c;
    valE = ve; valM = vm; srcA = sa; srcB = sb;
    #1;
    chk("dstE", 64'(dstE), 64'(m_dste(v, ic, rb, c)));
    if (v) chk("dstM", 64'(dstM), 64'(m_dstm(ic, ra)));
    chk("valA_pre", valA, m_regs[sa]);
    chk("valB_pre", valB, m_regs[sb]);
    @(posedge clk);
    model_step();
    #1;
    chk("valA_post", valA, m_regs[sa]);
    chk("valB_post", valB, m_regs[sb]);
    chk("retired", 64'(retired), 64'(m_ret));
    chk("halted", 64'(halted), 64'(m_halted));
    chk("instr_err", 64'(instr_err), 64'(m_err));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wb_valid = 1'b0;
    model_reset();
    #1;
    srcA = 4'h4; srcB = 4'h0;
    #1;
    chk("rst_valA_rsp", valA, RSP0);
    chk("rst_valB_r0", valB, 64'd0);
    chk("rst_retired", 64'(retired), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_err", 64'(instr_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  ic, ra, rb;
    logic        c;
    logic [63:0] ve, vm;
    logic [3:0]  sa, sb;
    logic [3:0]  exp_dste;
    logic [63:0] exp_a, exp_b;
    logic [31:0] exp_ret;
    logic        exp_halt;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{4'h3, 4'hF, 4'h2, 1'b0, 64'd42,   64'd0,   4'h2, 4'h0, 4'h2, 64'd42,   64'd0,   32'd1, 1'b0};
    tbl[1] = '{4'h2, 4'h2, 4'h3, 1'b0, 64'd7,    64'd0,   4'h3, 4'h2, 4'hF, 64'd0,    64'd42,  32'd2, 1'b0};
    tbl[2] = '{4'h2, 4'h2, 4'h3, 1'b1, 64'd7,    64'd0,   4'h3, 4'h4, 4'h3, 64'd7,    RSP0,    32'd3, 1'b0};
    tbl[3] = '{4'hB, 4'h4, 4'hF, 1'b0, 64'h108,  64'hAA,  4'h4, 4'h3, 4'h4, 64'hAA,   64'd7,   32'd4, 1'b0};
    tbl[4] = '{4'hB, 4'h1, 4'hF, 1'b0, 64'h108,  64'h5,   4'h1, 4'h4, 4'h4, 64'h5,    64'h108, 32'd5, 1'b0};
    tbl[5] = '{4'h1, 4'hF, 4'hF, 1'b0, 64'd0,    64'd0,   4'hF, 4'h2, 4'hF, 64'd0,    64'd42,  32'd6, 1'b0};
    tbl[6] = '{4'h0, 4'hF, 4'hF, 1'b0, 64'd0,    64'd0,   4'h1, 4'h2, 4'hF, 64'h5,    64'd42,  32'd7, 1'b1};
    tbl[7] = '{4'h6, 4'h2, 4'h1, 1'b0, 64'd9,    64'd0,   4'h1, 4'h4, 4'h1, 64'h5,    64'h108, 32'd7, 1'b1};

    rst_n = 1'b0; wb_valid = 1'b0; icode = 4'h1; rA = 4'hF; rB = 4'hF; cnd = 1'b0;
    valE = '0; valM = '0; srcA = 4'h0; srcB = 4'h0;
    @(negedge clk);
    do_reset();

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      chk("tbl_dstE", 64'(m_dste(1'b1, tbl[i].ic, tbl[i].rb, tbl[i].c)), 64'(tbl[i].exp_dste));
      run_cycle(1'b1, tbl[i].ic, tbl[i].ra, tbl[i].rb, tbl[i].c, tbl[i].ve, tbl[i].vm,
                tbl[i].sa, tbl[i].sb);
      chk("tbl_valA", valA, tbl[i].exp_a);
      chk("tbl_valB", valB, tbl[i].exp_b);
      chk("tbl_retired", 64'(retired), 64'(tbl[i].exp_ret));
      chk("tbl_halted", 64'(halted), 64'(tbl[i].exp_halt));
    end

    // Invalid icode: sticky error, no count, later retirements ignored
    do_reset();
    run_cycle(1'b1, 4'hC, 4'h1, 4'h2, 1'b0, 64'd3, 64'd4, 4'h1, 4'h2);
    chk("bad_err", 64'(instr_err), 64'd1);
    chk("bad_halt", 64'(halted), 64'd1);
    chk("bad_ret", 64'(retired), 64'd0);
    run_cycle(1'b1, 4'h3, 4'hF, 4'h2, 1'b0, 64'd77, 64'd0, 4'h2, 4'h4);
    chk("bad_nowrite", valA, 64'd0);

    // Asynchronous reset mid-cycle, holding across an edge with a write pending
    do_reset();
    run_cycle(1'b1, 4'h3, 4'hF, 4'h5, 1'b0, 64'h77, 64'd0, 4'h5, 4'h6);
    chk("pre_async_r5", valA, 64'h77);
    wb_valid = 1'b1; icode = 4'h3; rB = 4'h6; valE = 64'h99; srcA = 4'h5; srcB = 4'h6;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_r5", valA, 64'd0);
    chk("async_ret", 64'(retired), 64'd0);
    @(posedge clk);
    #1;
    chk("async_abort_r6", valB, 64'd0);
    chk("async_hold_ret", 64'(retired), 64'd0);
    @(negedge clk);
    wb_valid = 1'b0;
    rst_n = 1'b1;
    model_reset();

    // Randomized retirements against the model
    for (int n = 0; n < 600; n++) begin
      int unsigned sel;
      logic [3:0] ic;
      if (($urandom_range(0, 99) < 2) || (m_halted && $urandom_range(0, 99) < 15)) do_reset();
      sel = $urandom_range(0, 99);
      if (sel < 2)      ic = 4'h0;
      else if (sel < 4) ic = 4'(4'hC + $urandom_range(0, 3));
      else              ic = 4'($urandom_range(1, 11));
      run_cycle(1'($urandom_range(0, 3) != 0), ic, 4'($urandom), 4'($urandom),
                1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                4'($urandom), 4'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
